// File: rtl/ccm_pipe.sv
// 3x3 colour correction matrix with signed offsets, clamp, and frame-synchronised coefficient banks; optional CCM_ROUND_EN adds round-half-up.
// Latency: 3 cycles dvi->dvo in both enable modes; one pixel per cycle.
// Backpressure: none; the pipeline always advances.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

module ccm_pipe #(
    parameter int PIXEL_WIDTH      = 10,
    parameter int COEFF_WIDTH      = 8,
    parameter int COEFF_FRAC_WIDTH = 5,
    parameter int OFFSET_WIDTH     = PIXEL_WIDTH + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          dvi,
    input  logic [`DTYPE_WIDTH-1:0]       dtypei,
    input  logic [PIXEL_WIDTH-1:0]        ri,
    input  logic [PIXEL_WIDTH-1:0]        gi,
    input  logic [PIXEL_WIDTH-1:0]        bi,
    input  logic [15:0]                   meta_datai,
    input  logic                          frame_start,
    input  logic                          coeff_we,
    input  logic [3:0]                    coeff_addr,
    input  logic [((COEFF_WIDTH > OFFSET_WIDTH) ? COEFF_WIDTH : OFFSET_WIDTH)-1:0] coeff_data,
    input  logic                          coeff_commit,
    output logic                          commit_pending,
    output logic                          dvo,
    output logic [`DTYPE_WIDTH-1:0]       dtypeo,
    output logic [PIXEL_WIDTH-1:0]        ro,
    output logic [PIXEL_WIDTH-1:0]        go,
    output logic [PIXEL_WIDTH-1:0]        bo,
    output logic [15:0]                   meta_datao
);

    localparam int PROD_W  = COEFF_WIDTH + PIXEL_WIDTH + 1;
    localparam int ACC_W   = PIXEL_WIDTH + COEFF_WIDTH + 3;
    localparam int SAT_LSB = PIXEL_WIDTH + COEFF_FRAC_WIDTH;
`ifdef CCM_ROUND_EN
    localparam int RND_I = 1 << (COEFF_FRAC_WIDTH - 1);
`else
    localparam int RND_I = 0;
`endif
    localparam logic signed [COEFF_WIDTH-1:0] COEFF_ONE = COEFF_WIDTH'(1 << COEFF_FRAC_WIDTH);

    logic signed [COEFF_WIDTH-1:0]  shd_m [9];
    logic signed [COEFF_WIDTH-1:0]  act_m [9];
    logic signed [OFFSET_WIDTH-1:0] shd_o [3];
    logic signed [OFFSET_WIDTH-1:0] act_o [3];
    logic                           copy;

    // A commit arriving together with frame_start is applied immediately.
    assign copy = frame_start && (commit_pending || coeff_commit);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                shd_m[i] <= (i % 4 == 0) ? COEFF_ONE : '0;
                act_m[i] <= (i % 4 == 0) ? COEFF_ONE : '0;
            end
            for (int i = 0; i < 3; i++) begin
                shd_o[i] <= '0;
                act_o[i] <= '0;
            end
            commit_pending <= 1'b0;
        end else begin
            if (copy) begin
                for (int i = 0; i < 9; i++) act_m[i] <= shd_m[i];
                for (int i = 0; i < 3; i++) act_o[i] <= shd_o[i];
            end
            if (coeff_we) begin
                for (int i = 0; i < 9; i++)
                    if (coeff_addr == 4'(i)) shd_m[i] <= coeff_data[COEFF_WIDTH-1:0];
                for (int i = 0; i < 3; i++)
                    if (coeff_addr == 4'(i + 9)) shd_o[i] <= coeff_data[OFFSET_WIDTH-1:0];
            end
            if (copy)
                commit_pending <= 1'b0;
            else if (coeff_commit)
                commit_pending <= 1'b1;
        end
    end

    logic signed [PIXEL_WIDTH:0] pix_x [3];
    assign pix_x[0] = $signed({1'b0, ri});
    assign pix_x[1] = $signed({1'b0, gi});
    assign pix_x[2] = $signed({1'b0, bi});

    logic                           s1_vld, s1_en;
    logic [`DTYPE_WIDTH-1:0]        s1_dtype;
    logic [15:0]                    s1_meta;
    logic [PIXEL_WIDTH-1:0]         s1_pix  [3];
    logic signed [PROD_W-1:0]       s1_prod [9];
    logic signed [OFFSET_WIDTH-1:0] s1_off  [3];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld   <= 1'b0;
            s1_en    <= 1'b0;
            s1_dtype <= '0;
            s1_meta  <= '0;
            for (int i = 0; i < 3; i++) begin
                s1_pix[i] <= '0;
                s1_off[i] <= '0;
            end
            for (int k = 0; k < 9; k++) s1_prod[k] <= '0;
        end else begin
            s1_vld    <= dvi;
            s1_en     <= enable;
            s1_dtype  <= dtypei;
            s1_meta   <= meta_datai;
            s1_pix[0] <= ri;
            s1_pix[1] <= gi;
            s1_pix[2] <= bi;
            // Products index row-major: k = row*3 + col, col selects r/g/b.
            for (int k = 0; k < 9; k++)
                s1_prod[k] <= PROD_W'(act_m[k]) * PROD_W'(pix_x[k % 3]);
            for (int i = 0; i < 3; i++) s1_off[i] <= act_o[i];
        end
    end

    logic                      s2_vld, s2_en;
    logic [`DTYPE_WIDTH-1:0]   s2_dtype;
    logic [15:0]               s2_meta;
    logic [PIXEL_WIDTH-1:0]    s2_pix [3];
    logic signed [ACC_W-1:0]   s2_acc [3];

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_vld   <= 1'b0;
            s2_en    <= 1'b0;
            s2_dtype <= '0;
            s2_meta  <= '0;
            for (int i = 0; i < 3; i++) begin
                s2_pix[i] <= '0;
                s2_acc[i] <= '0;
            end
        end else begin
            s2_vld   <= s1_vld;
            s2_en    <= s1_en;
            s2_dtype <= s1_dtype;
            s2_meta  <= s1_meta;
            for (int i = 0; i < 3; i++) begin
                s2_pix[i] <= s1_pix[i];
                s2_acc[i] <= ACC_W'(s1_prod[3*i]) + ACC_W'(s1_prod[3*i+1]) + ACC_W'(s1_prod[3*i+2])
                           + (ACC_W'(s1_off[i]) <<< COEFF_FRAC_WIDTH) + ACC_W'(RND_I);
            end
        end
    end

    function automatic logic [PIXEL_WIDTH-1:0] clamp(input logic signed [ACC_W-1:0] a);
        if (a[ACC_W-1])
            return '0;
        if (|a[ACC_W-2:SAT_LSB])
            return '1;
        return a[SAT_LSB-1:COEFF_FRAC_WIDTH];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            dvo        <= 1'b0;
            dtypeo     <= '0;
            meta_datao <= '0;
            ro         <= '0;
            go         <= '0;
            bo         <= '0;
        end else begin
            dvo        <= s2_vld;
            dtypeo     <= s2_dtype;
            meta_datao <= s2_meta;
            ro         <= s2_en ? clamp(s2_acc[0]) : s2_pix[0];
            go         <= s2_en ? clamp(s2_acc[1]) : s2_pix[1];
            bo         <= s2_en ? clamp(s2_acc[2]) : s2_pix[2];
        end
    end

endmodule

// File: tb/tb_ccm_pipe.sv
// Bench for ccm_pipe: directed scenarios with literal expectations plus a randomized run
// checked against an integer-arithmetic reference of the matrix, clamp and commit rules.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

module tb_ccm_pipe;

    logic                    clk = 1'b0;
    logic                    reset, enable, dvi, frame_start, coeff_we, coeff_commit;
    logic [`DTYPE_WIDTH-1:0] dtypei, dtypeo;
    logic [9:0]              ri, gi, bi, ro, go, bo;
    logic [15:0]             meta_datai, meta_datao;
    logic [3:0]              coeff_addr;
    logic [10:0]             coeff_data;
    logic                    commit_pending, dvo;

    int n_vec  = 0;
    int n_fail = 0;

`ifdef CCM_ROUND_EN
    localparam logic [9:0] ROUND_EXP = 10'd5;
`else
    localparam logic [9:0] ROUND_EXP = 10'd4;
`endif

    ccm_pipe dut (
        .clk(clk), .reset(reset), .enable(enable), .dvi(dvi), .dtypei(dtypei),
        .ri(ri), .gi(gi), .bi(bi), .meta_datai(meta_datai), .frame_start(frame_start),
        .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .coeff_commit(coeff_commit), .commit_pending(commit_pending), .dvo(dvo),
        .dtypeo(dtypeo), .ro(ro), .go(go), .bo(bo), .meta_datao(meta_datao)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                    dv;
        logic [`DTYPE_WIDTH-1:0] dt;
        logic [15:0]             meta;
        logic [9:0]              r, g, b;
    } exp_t;

    // Reference state: coefficients as plain signed integers (index 9..11 = offsets)
    int   sh [12];
    int   act[12];
    bit   pend;
    exp_t dline[$];
    exp_t exp_now;

    function automatic void bank_reset();
        for (int i = 0; i < 12; i++) sh[i] = (i == 0 || i == 4 || i == 8) ? 32 : 0;
        act  = sh;
        pend = 1'b0;
    endfunction

    function automatic logic [9:0] ccm_row(int row, int r, int g, int b);
        int acc;
        acc = act[row*3] * r + act[row*3+1] * g + act[row*3+2] * b + act[9+row] * 32;
`ifdef CCM_ROUND_EN
        acc = acc + 16;
`endif
        if (acc < 0) return 10'd0;
        if (acc >= 1024 * 32) return 10'd1023;
        return 10'(acc / 32);
    endfunction

    // One clock: apply the reference to the inputs currently driven, then advance.
    task automatic step();
        exp_t e;
        bit   copy;
        logic signed [7:0]  c8;
        logic signed [10:0] c11;
        if (reset) begin
            bank_reset();
            @(posedge clk); #1;
            dline.delete();
            dline.push_back('0);
            dline.push_back('0);
            exp_now = '0;
            return;
        end
        e.dv   = dvi;
        e.dt   = dtypei;
        e.meta = meta_datai;
        e.r    = enable ? ccm_row(0, int'(ri), int'(gi), int'(bi)) : ri;
        e.g    = enable ? ccm_row(1, int'(ri), int'(gi), int'(bi)) : gi;
        e.b    = enable ? ccm_row(2, int'(ri), int'(gi), int'(bi)) : bi;
        copy = frame_start && (pend || coeff_commit);
        if (copy) act = sh;
        if (coeff_we) begin
            c8  = coeff_data[7:0];
            c11 = coeff_data;
            if (coeff_addr < 4'd9) sh[coeff_addr] = int'(c8);
            else if (coeff_addr < 4'd12) sh[coeff_addr] = int'(c11);
        end
        if (copy) pend = 1'b0;
        else if (coeff_commit) pend = 1'b1;
        @(posedge clk); #1;
        dline.push_back(e);
        exp_now = dline.pop_front();
    endtask

    task automatic wr(input int a, input int d);
        coeff_we = 1'b1; coeff_addr = 4'(a); coeff_data = 11'(d);
        step();
        coeff_we = 1'b0;
    endtask

    task automatic commit_now();
        coeff_commit = 1'b1; frame_start = 1'b1;
        step();
        coeff_commit = 1'b0; frame_start = 1'b0;
    endtask

    task automatic pix(input int r, input int g, input int b);
        dvi = 1'b1; ri = 10'(r); gi = 10'(g); bi = 10'(b);
        step();
        dvi = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_vec++;
        if ({dvo, commit_pending, dtypeo, meta_datao} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: dvo=%0b pend=%0b dtype=%0h meta=%0h exp all 0", dvo, commit_pending, dtypeo, meta_datao);
        end
        n_vec++;
        if ({ro, go, bo} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_pix: rgb=%0d,%0d,%0d exp 0,0,0", ro, go, bo);
        end
        reset = 1'b0;
    endtask

    task automatic test_identity();
        dtypei = 4'hA; meta_datai = 16'hBEEF;
        pix(100, 200, 300);
        step();
        n_vec++;
        if (dvo !== 1'b0) begin
            n_fail++;
            $display("FAIL ident_early: dvo=%0b exp 0", dvo);
        end
        step();
        n_vec++;
        if ({dvo, ro, go, bo} !== {1'b1, 10'd100, 10'd200, 10'd300}) begin
            n_fail++;
            $display("FAIL ident_pix: dvo=%0b rgb=%0d,%0d,%0d exp 1 100,200,300", dvo, ro, go, bo);
        end
        n_vec++;
        if ({dtypeo, meta_datao} !== {4'hA, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL ident_side: dtype=%0h meta=%0h exp a beef", dtypeo, meta_datao);
        end
    endtask

    task automatic test_commit();
        wr(0, 'h40);
        coeff_commit = 1'b1;
        step();
        coeff_commit = 1'b0;
        n_vec++;
        if (commit_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL commit_pend_set: pend=%0b exp 1", commit_pending);
        end
        pix(100, 0, 0);
        step(); step();
        n_vec++;
        if (ro !== 10'd100) begin
            n_fail++;
            $display("FAIL commit_before_fs: ro=%0d exp 100", ro);
        end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        n_vec++;
        if (commit_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_pend_clr: pend=%0b exp 0", commit_pending);
        end
        pix(100, 0, 0);
        pix(600, 0, 0);
        step();
        n_vec++;
        if (ro !== 10'd200) begin
            n_fail++;
            $display("FAIL commit_rr2: ro=%0d exp 200", ro);
        end
        step();
        n_vec++;
        if (ro !== 10'd1023) begin
            n_fail++;
            $display("FAIL commit_clamp_hi: ro=%0d exp 1023", ro);
        end
    endtask

    task automatic test_same_cycle_commit();
        do_reset();
        wr(1, 'hE0);
        commit_now();
        n_vec++;
        if (commit_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_pend: pend=%0b exp 0", commit_pending);
        end
        pix(100, 200, 0);
        step(); step();
        n_vec++;
        if (ro !== 10'd0) begin
            n_fail++;
            $display("FAIL clamp_neg: ro=%0d exp 0", ro);
        end
        wr(9, 50);
        commit_now();
        pix(300, 100, 0);
        step(); step();
        n_vec++;
        if (ro !== 10'd250) begin
            n_fail++;
            $display("FAIL offset_r: ro=%0d exp 250", ro);
        end
    endtask

    task automatic test_round();
        do_reset();
        wr(0, 'h30);
        commit_now();
        pix(3, 0, 0);
        step(); step();
        n_vec++;
        if (ro !== ROUND_EXP) begin
            n_fail++;
            $display("FAIL round: ro=%0d exp %0d", ro, ROUND_EXP);
        end
    endtask

    task automatic test_we_during_copy();
        do_reset();
        wr(0, 'h40);
        coeff_commit = 1'b1;
        step();
        coeff_commit = 1'b0;
        frame_start = 1'b1; coeff_we = 1'b1; coeff_addr = 4'd0; coeff_data = 11'h60;
        step();
        frame_start = 1'b0; coeff_we = 1'b0;
        pix(100, 0, 0);
        step(); step();
        n_vec++;
        if (ro !== 10'd200) begin
            n_fail++;
            $display("FAIL we_copy_old: ro=%0d exp 200", ro);
        end
        commit_now();
        pix(100, 0, 0);
        step(); step();
        n_vec++;
        if (ro !== 10'd300) begin
            n_fail++;
            $display("FAIL we_copy_new: ro=%0d exp 300", ro);
        end
    endtask

    task automatic test_bypass();
        enable = 1'b0;
        pix(500, 600, 700);
        step(); step();
        n_vec++;
        if ({dvo, ro, go, bo} !== {1'b1, 10'd500, 10'd600, 10'd700}) begin
            n_fail++;
            $display("FAIL bypass: dvo=%0b rgb=%0d,%0d,%0d exp 1 500,600,700", dvo, ro, go, bo);
        end
        enable = 1'b1;
        pix(100, 0, 0);
        enable = 1'b0;
        pix(100, 0, 0);
        enable = 1'b1;
        step();
        n_vec++;
        if (ro !== 10'd300) begin
            n_fail++;
            $display("FAIL toggle_on: ro=%0d exp 300", ro);
        end
        step();
        n_vec++;
        if (ro !== 10'd100) begin
            n_fail++;
            $display("FAIL toggle_off: ro=%0d exp 100", ro);
        end
    endtask

    task automatic test_reset_midstream();
        pix(10, 20, 30);
        pix(40, 50, 60);
        dvi = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        dvi = 1'b0;
        n_vec++;
        if (dvo !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_dvo: dvo=%0b exp 0", dvo);
        end
        step(); step();
        n_vec++;
        if (dvo !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_flush: dvo=%0b exp 0", dvo);
        end
        pix(100, 200, 300);
        step(); step();
        n_vec++;
        if ({dvo, ro, go, bo} !== {1'b1, 10'd100, 10'd200, 10'd300}) begin
            n_fail++;
            $display("FAIL midreset_ident: dvo=%0b rgb=%0d,%0d,%0d exp 1 100,200,300", dvo, ro, go, bo);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset        = ($urandom_range(0, 199) == 0);
            dvi          = ($urandom_range(0, 3) != 0);
            enable       = ($urandom_range(0, 4) != 0);
            ri           = 10'($urandom);
            gi           = 10'($urandom);
            bi           = 10'($urandom);
            dtypei       = `DTYPE_WIDTH'($urandom);
            meta_datai   = 16'($urandom);
            coeff_we     = ($urandom_range(0, 3) == 0);
            coeff_addr   = 4'($urandom);
            coeff_data   = 11'($urandom_range(0, 96)) - 11'd32;
            coeff_commit = ($urandom_range(0, 11) == 0);
            frame_start  = ($urandom_range(0, 15) == 0);
            step();
            n_vec++;
            if (dvo !== exp_now.dv || commit_pending !== pend) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: dvo=%0b pend=%0b exp %0b %0b", n, dvo, commit_pending, exp_now.dv, pend);
            end
            if (exp_now.dv) begin
                n_vec++;
                if ({ro, go, bo, dtypeo, meta_datao} !== {exp_now.r, exp_now.g, exp_now.b, exp_now.dt, exp_now.meta}) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: rgb=%0d,%0d,%0d dt=%0h meta=%0h exp %0d,%0d,%0d dt=%0h meta=%0h",
                             n, ro, go, bo, dtypeo, meta_datao, exp_now.r, exp_now.g, exp_now.b, exp_now.dt, exp_now.meta);
                end
            end
        end
        reset = 1'b0; dvi = 1'b0; coeff_we = 1'b0; coeff_commit = 1'b0; frame_start = 1'b0; enable = 1'b1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; dvi = 1'b0; frame_start = 1'b0; coeff_we = 1'b0;
        coeff_commit = 1'b0; dtypei = '0; ri = '0; gi = '0; bi = '0; meta_datai = '0;
        coeff_addr = '0; coeff_data = '0;
        test_reset();
        test_identity();
        test_commit();
        test_same_cycle_commit();
        test_round();
        test_we_during_copy();
        test_bypass();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ccm_pipe.md
# ccm_pipe

Pipelined, parametrised 3×3 colour correction matrix with per-channel signed offsets and double-buffered coefficients. It takes unsigned RGB pixels and applies `out = M·in + offset`, then clamps each result to the pixel range. New coefficients are loaded through a write port into shadow registers and take effect only at a frame boundary, so a frame is never processed with a mix of old and new coefficients. The block sits in the RGB pipeline after demosaic and before gamma/colour-space conversion.

## Interface
Parameters:
- PIXEL_WIDTH, 10, unsigned pixel width in and out
- COEFF_WIDTH, 8, signed two's-complement coefficient width
- COEFF_FRAC_WIDTH, 5, fractional bits of each coefficient (1.0 = 2^COEFF_FRAC_WIDTH)
- OFFSET_WIDTH, PIXEL_WIDTH+1, signed offset width, in integer pixel units

Ports:
- clk, in, 1, the only clock
- reset, in, 1, synchronous, active-high reset
- enable, in, 1, 1 = apply matrix and offset; 0 = bypass (inputs pass through with the same latency)
- dvi, in, 1, input data valid
- dtypei, in, `DTYPE_WIDTH, data type sideband
- ri / gi / bi, in, PIXEL_WIDTH each, input pixel
- meta_datai, in, 16, metadata sideband
- frame_start, in, 1, one-cycle pulse at frame boundary
- coeff_we, in, 1, shadow register write strobe
- coeff_addr, in, 4, register index: 0–8 = RR,RG,RB,GR,GG,GB,BR,BG,BB; 9–11 = R/G/B offset; 12–15 are ignored
- coeff_data, in, max(COEFF_WIDTH,OFFSET_WIDTH), write data, LSB-aligned
- coeff_commit, in, 1, request to copy shadow registers to active at the next frame_start
- commit_pending, out, 1, a commit has been requested but not yet applied
- dvo, out, 1, output valid
- dtypeo, out, `DTYPE_WIDTH, delayed dtypei
- ro / go / bo, out, PIXEL_WIDTH each, output pixel
- meta_datao, out, 16, delayed meta_datai

## Operation
Each output row is computed from all three inputs:
- ro = RR·r + RG·g + RB·b + OR
- go = GR·r + GG·g + GB·b + OG
- bo = BR·r + BG·g + BB·b + OB

Arithmetic:
- Inputs are zero-extended to PIXEL_WIDTH+1 bits and treated as signed.
- Products are signed.
- The accumulator is ACC = PIXEL_WIDTH+COEFF_WIDTH+3 bits.
- Each offset is sign-extended and shifted left by COEFF_FRAC_WIDTH before it is added.

Clamp:
- ACC negative → output 0.
- ACC ≥ 2^(PIXEL_WIDTH+COEFF_FRAC_WIDTH) → output all ones.
- Otherwise → output ACC[COEFF_FRAC_WIDTH+PIXEL_WIDTH-1:COEFF_FRAC_WIDTH].

Coefficient registers:
- There are two banks, shadow and active. coeff_we writes the shadow bank only. The datapath reads the active bank only.
- coeff_commit sets the pending flag. When frame_start is high and the flag is set, active ← shadow and the flag clears.
- If coeff_commit and frame_start arrive in the same cycle, the copy happens that cycle.
- If coeff_we and a copy happen in the same cycle, the copy takes the pre-write shadow value. The new write lands in shadow and waits for the next commit.
- coeff_commit while the flag is already set has no additional effect.

Reset values:
- Both banks: diagonal = 2^COEFF_FRAC_WIDTH, off-diagonal = 0, offsets = 0 (identity).
- Pending flag = 0.
- All outputs = 0, including dvo, dtypeo, meta_datao, ro, go, bo and commit_pending.

Bypass:
- enable = 0 outputs ri/gi/bi delayed by the pipeline latency.
- enable is sampled in stage 1 and travels with the pixel, so toggling it affects whole pixels only.

## Timing
Pipeline stages:
- Stage 1: register the inputs and the 9 products.
- Stage 2: form the sums plus offset (plus rounding constant, see Configuration).
- Stage 3: clamp and register the outputs.

Latency and throughput:
- Latency is 3 cycles from a dvi sample to dvo, in both enable modes. Throughput is one pixel per cycle; there is no backpressure.
- dvi, dtypei and meta_datai are delayed 3 cycles alongside the data.

Coefficient timing:
- An active-bank update at cycle N applies to pixels sampled at cycle N+1 onward. The pixel sampled at cycle N uses the old coefficients.
- commit_pending is a register. It rises the cycle after coeff_commit and falls the cycle after the copy.

Reset:
- Reset is synchronous. Asserting it mid-stream clears all pipeline valids, so dvo = 0 on the next edge.
- In-flight pixels are discarded.
- Both coefficient banks return to identity.

## Configuration
- CCM_ROUND_EN defined: add 2^(COEFF_FRAC_WIDTH-1) to ACC in stage 2 before the clamp, giving round-half-up.
- CCM_ROUND_EN undefined: truncate (floor).
- Latency is identical in both builds.

## Test plan
All scenarios use the default parameters.
- After reset, identity coefficients: r,g,b = 100,200,300 with dvi = 1 → 3 cycles later dvo = 1, outputs 100,200,300; dtypeo/meta_datao match the inputs.
- Write RR = 0x40 (2.0), commit, pulse frame_start. r = 100 → ro = 200; r = 600 → ro = 1023 (clamp). Before the frame_start pulse, ro stays 100 and commit_pending = 1.
- Write RG = 0xE0 (−1.0) and commit with frame_start in the same cycle. r,g = 100,200 → ro = 0. Then write offset R = 50 and commit: r,g = 300,100 → ro = 250.
- Rounding: RR = 0x30 (1.5), r = 3 → ro = 5 with CCM_ROUND_EN, 4 without.
- coeff_we to RR on the same cycle as a pending copy → the active bank gets the old shadow value; the new value appears only after the next commit plus frame_start.
- enable = 0 with a non-identity matrix → outputs equal the inputs after 3 cycles. Reset asserted mid-stream → dvo = 0 on the next edge, and identity coefficients afterwards.
